// File: rtl/ball_motion_ctrl_pkg.sv
// ball_motion_ctrl_pkg: shared ball state encoding and default playfield geometry
package ball_motion_ctrl_pkg;
    typedef enum logic [1:0] {ST_SERVE, ST_MOVE, ST_PAUSED} ball_state_e;
    localparam int POS_W         = 9;
    localparam int DEF_H_LIMIT   = 256;
    localparam int DEF_V_LIMIT   = 240;
    localparam int DEF_BALL_SIZE = 4;
endpackage

// File: rtl/ball_motion_ctrl_axis_reflect.sv
// ball_motion_ctrl_axis_reflect: one-axis step with wall clamp and velocity reflection
module ball_motion_ctrl_axis_reflect
    import ball_motion_ctrl_pkg::*;
#(
    parameter int MAX = DEF_H_LIMIT - DEF_BALL_SIZE
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic [POS_W-1:0] vel_i,
    output logic [POS_W-1:0] pos_o,
    output logic [POS_W-1:0] vel_o,
    output logic             bounce_o
);
    logic signed [POS_W:0] n;
    logic lo, hi;
    always_comb begin
        n        = $signed({1'b0, pos_i}) + $signed({vel_i[POS_W-1], vel_i});
        lo       = n < 0;
        hi       = n > $signed((POS_W+1)'(MAX));
        pos_o    = lo ? '0 : hi ? POS_W'(MAX) : n[POS_W-1:0];
        vel_o    = (lo | hi) ? -vel_i : vel_i;
        bounce_o = lo | hi;
    end
endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: frame-tick ball kinematics with serve delay, pause and wall bounces
module ball_motion_ctrl
    import ball_motion_ctrl_pkg::*;
#(
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int H_LIMIT      = DEF_H_LIMIT,
    parameter int V_LIMIT      = DEF_V_LIMIT,
    parameter int INIT_X       = 128,
    parameter int INIT_Y       = 128,
    parameter int INIT_DX      = -2,
    parameter int INIT_DY      = 2,
    parameter int SERVE_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             launch,
    input  logic             pause,
    output logic [POS_W-1:0] ball_hpos,
    output logic [POS_W-1:0] ball_vpos,
    output logic             bounce_h,
    output logic             bounce_v,
    output logic             moving
);
    localparam int CW = SERVE_FRAMES > 1 ? $clog2(SERVE_FRAMES) : 1;

    ball_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d, dx_q, dx_d, dy_q, dy_d;
    logic [POS_W-1:0] nh, nv, ndx, ndy;
    logic             bh_q, bh_d, bv_q, bv_d, mv_q, vsync_q, tick, hit_h, hit_v;

    ball_motion_ctrl_axis_reflect #(.MAX(H_LIMIT - BALL_SIZE)) u_x (
        .pos_i(hpos_q), .vel_i(dx_q), .pos_o(nh), .vel_o(ndx), .bounce_o(hit_h)
    );
    ball_motion_ctrl_axis_reflect #(.MAX(V_LIMIT - BALL_SIZE)) u_y (
        .pos_i(vpos_q), .vel_i(dy_q), .pos_o(nv), .vel_o(ndy), .bounce_o(hit_v)
    );

    assign tick = vsync & ~vsync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        bh_d    = 1'b0;
        bv_d    = 1'b0;
        case (state_q)
            ST_SERVE: if (tick) begin
                cnt_d = cnt_q + 1'b1;
                if (launch || cnt_q == CW'(SERVE_FRAMES - 1)) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                // pause wins over a coincident tick: no step is taken that cycle
                if (pause) state_d = ST_PAUSED;
                else if (tick) begin
                    hpos_d = nh;
                    vpos_d = nv;
                    dx_d   = ndx;
                    dy_d   = ndy;
                    bh_d   = hit_h;
                    bv_d   = hit_v;
                end
            end
            ST_PAUSED: if (!pause) state_d = ST_MOVE;
            default:   state_d = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SERVE;
            cnt_q   <= '0;
            hpos_q  <= POS_W'(INIT_X);
            vpos_q  <= POS_W'(INIT_Y);
            dx_q    <= POS_W'(INIT_DX);
            dy_q    <= POS_W'(INIT_DY);
            bh_q    <= 1'b0;
            bv_q    <= 1'b0;
            mv_q    <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            bh_q    <= bh_d;
            bv_q    <= bv_d;
            mv_q    <= state_d == ST_MOVE;
            vsync_q <= vsync;
        end
    end

    assign ball_hpos = hpos_q;
    assign ball_vpos = vpos_q;
    assign bounce_h  = bh_q;
    assign bounce_v  = bv_q;
    assign moving    = mv_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: five differently initialised instances checked via an expectation queue
module tb_ball_motion_ctrl;
    logic clk = 1'b0, reset = 1'b0, vsync = 1'b1, pause_a = 1'b0;
    logic [8:0] hp [5];
    logic [8:0] vp [5];
    logic       bh [5];
    logic       bv [5];
    logic       mv [5];
    int cyc = 0, total = 0, bad = 0;

    typedef struct {
        int stamp; int id; logic [8:0] h; logic [8:0] v;
        logic bh; logic bv; logic mv; string name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ball_motion_ctrl #(.SERVE_FRAMES(2)) u_a (.clk(clk), .reset(reset), .vsync(vsync),
        .launch(1'b0), .pause(pause_a), .ball_hpos(hp[0]), .ball_vpos(vp[0]),
        .bounce_h(bh[0]), .bounce_v(bv[0]), .moving(mv[0]));
    ball_motion_ctrl #(.SERVE_FRAMES(2), .INIT_X(1)) u_b (.clk(clk), .reset(reset), .vsync(vsync),
        .launch(1'b1), .pause(1'b0), .ball_hpos(hp[1]), .ball_vpos(vp[1]),
        .bounce_h(bh[1]), .bounce_v(bv[1]), .moving(mv[1]));
    ball_motion_ctrl #(.SERVE_FRAMES(2), .INIT_Y(235)) u_c (.clk(clk), .reset(reset), .vsync(vsync),
        .launch(1'b1), .pause(1'b0), .ball_hpos(hp[2]), .ball_vpos(vp[2]),
        .bounce_h(bh[2]), .bounce_v(bv[2]), .moving(mv[2]));
    ball_motion_ctrl #(.SERVE_FRAMES(2), .INIT_Y(234)) u_d (.clk(clk), .reset(reset), .vsync(vsync),
        .launch(1'b1), .pause(1'b0), .ball_hpos(hp[3]), .ball_vpos(vp[3]),
        .bounce_h(bh[3]), .bounce_v(bv[3]), .moving(mv[3]));
    ball_motion_ctrl #(.SERVE_FRAMES(2), .INIT_X(253), .INIT_Y(237), .INIT_DX(3), .INIT_DY(1)) u_e (
        .clk(clk), .reset(reset), .vsync(vsync), .launch(1'b1), .pause(1'b0),
        .ball_hpos(hp[4]), .ball_vpos(vp[4]), .bounce_h(bh[4]), .bounce_v(bv[4]), .moving(mv[4]));

    task automatic chk(input int dly, input int id, input int h, input int v,
                       input bit b_h, input bit b_v, input bit m, input string name);
        exp_t e;
        e.stamp = cyc + dly; e.id = id; e.h = 9'(h); e.v = 9'(v);
        e.bh = b_h; e.bv = b_v; e.mv = m; e.name = name;
        sb.push_back(e);
    endtask

    task automatic rise();
        @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic fall();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.stamp != cyc ||
                {hp[e.id], vp[e.id], bh[e.id], bv[e.id], mv[e.id]} !== {e.h, e.v, e.bh, e.bv, e.mv}) begin
                bad++;
                $display("FAIL %s: got h=%0d v=%0d bh=%b bv=%b mv=%b, want h=%0d v=%0d bh=%b bv=%b mv=%b",
                         e.name, hp[e.id], vp[e.id], bh[e.id], bv[e.id], mv[e.id],
                         e.h, e.v, e.bh, e.bv, e.mv);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk(2, 0, 128, 128, 0, 0, 0, "rst_a");
        chk(2, 1, 1,   128, 0, 0, 0, "rst_b");
        chk(2, 2, 128, 235, 0, 0, 0, "rst_c");
        chk(2, 3, 128, 234, 0, 0, 0, "rst_d");
        chk(2, 4, 253, 237, 0, 0, 0, "rst_e");
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        rise();
        chk(1, 0, 128, 128, 0, 0, 0, "serve1_a");
        chk(1, 1, 1,   128, 0, 0, 1, "launch_b");
        fall();
        rise();
        chk(1, 0, 128, 128, 0, 0, 1, "serve2_a");
        chk(1, 1, 0,   130, 1, 0, 1, "left_wall_b");
        chk(1, 2, 126, 236, 0, 1, 1, "bottom_clamp_c");
        chk(1, 3, 126, 236, 0, 0, 1, "bottom_exact_d");
        chk(1, 4, 252, 236, 1, 1, 1, "corner_e");
        chk(2, 1, 0,   130, 0, 0, 1, "pulse_end_b");
        chk(2, 2, 126, 236, 0, 0, 1, "pulse_end_c");
        chk(2, 4, 252, 236, 0, 0, 1, "pulse_end_e");
        fall();
        rise();
        chk(1, 0, 126, 130, 0, 0, 1, "step_a");
        chk(1, 1, 2,   132, 0, 0, 1, "after_wall_b");
        chk(1, 2, 124, 234, 0, 0, 1, "after_clamp_c");
        chk(1, 3, 124, 236, 0, 1, 1, "bottom_bounce_d");
        chk(1, 4, 249, 235, 0, 0, 1, "after_corner_e");
        fall();
        @(negedge clk);
        pause_a = 1'b1;
        chk(1, 0, 126, 130, 0, 0, 0, "pause_enter_a");
        for (int i = 0; i < 3; i++) begin
            rise();
            chk(1, 0, 126, 130, 0, 0, 0, "paused_tick_a");
            fall();
        end
        @(negedge clk);
        pause_a = 1'b0;
        chk(1, 0, 126, 130, 0, 0, 1, "unpause_a");
        rise();
        chk(1, 0, 124, 132, 0, 0, 1, "resume_step_a");
        chk(2, 0, 124, 132, 0, 0, 1, "single_step_a");
        fall();
        @(posedge clk);
        #1 reset = 1'b0;
        chk(0, 0, 128, 128, 0, 0, 0, "async_rst_a");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rise();
        chk(1, 0, 128, 128, 0, 0, 0, "reserve1_a");
        fall();
        rise();
        chk(1, 0, 128, 128, 0, 0, 1, "reserve2_a");
        fall();
        rise();
        chk(1, 0, 126, 130, 0, 0, 1, "restep_a");
        fall();
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
